// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
// Owner index width covers up to eight requesters.
package mem_bus_arbiter_pkg;

  localparam int OWNER_W = 3;
  localparam int DEF_MAX_BURST = 16;
  localparam int BEAT_W = 8;
  localparam logic [BEAT_W-1:0] BEAT_SAT = 8'd255;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWNED = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-slave signal bundle around the arbiter.
// The slave modport is the arbiter's view; master is the environment.
interface mem_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();

  logic [NUM_MASTERS-1:0]        m_req;
  logic [NUM_MASTERS-1:0]        m_we;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]        m_grant;
  logic [NUM_MASTERS-1:0]        m_ready;
  logic [DATA_W-1:0]             m_rdata;
  logic                          s_req;
  logic                          s_we;
  logic [ADDR_W-1:0]             s_addr;
  logic [DATA_W-1:0]             s_wdata;
  logic [DATA_W-1:0]             s_rdata;
  logic                          s_ready;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    input  s_rdata, s_ready,
    output m_grant, m_ready, m_rdata,
    output s_req, s_we, s_addr, s_wdata
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    output s_rdata, s_ready,
    input  m_grant, m_ready, m_rdata,
    input  s_req, s_we, s_addr, s_wdata
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first request after last,
// wrapping modulo the requester count.
module mem_bus_arbiter_rr_pick
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [OWNER_W-1:0]     last,
  output logic                   found,
  output logic [OWNER_W-1:0]     idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!found && req[i] &&
            i == (int'(last) + k) % NUM_MASTERS) begin
          found = 1'b1;
          idx   = OWNER_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory slave port, with burst
// limit and a one-cycle turnaround between owners.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic               clk,
  input  logic               resetn,
  mem_bus_arbiter_if.slave   bus,
  output logic [OWNER_W-1:0] owner,
  output logic               busy
);

  localparam int N = NUM_MASTERS;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  arb_state_e          state, state_n;
  logic [N-1:0]        grant, grant_n;
  logic [OWNER_W-1:0]  owner_n;
  logic [OWNER_W-1:0]  last, last_n;
  logic                busy_n;
  logic [BEAT_W-1:0]   cnt, cnt_n;

  logic                found;
  logic [OWNER_W-1:0]  pick;
  logic                own_req;
  logic                others;
  logic                beat;
  logic                limit;

  logic                s_we;
  logic [ADDR_W-1:0]   s_addr;
  logic [DATA_W-1:0]   s_wdata;

  mem_bus_arbiter_rr_pick #(
    .NUM_MASTERS(N)
  ) u_pick (
    .req   (bus.m_req),
    .last  (last),
    .found (found),
    .idx   (pick)
  );

  assign own_req = |(bus.m_req & grant);
  assign others  = |(bus.m_req & ~grant);
  assign beat    = bus.s_req & bus.s_ready;
  // >= so an owner past its limit still yields once someone waits
  assign limit   = cnt >= BEAT_W'(MAX_BURST - 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ARB_IDLE;
      grant <= '0;
      owner <= '0;
      busy  <= 1'b0;
      cnt   <= '0;
      last  <= OWNER_W'(N - 1);
    end else begin
      state <= state_n;
      grant <= grant_n;
      owner <= owner_n;
      busy  <= busy_n;
      cnt   <= cnt_n;
      last  <= last_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    owner_n = owner;
    busy_n  = busy;
    cnt_n   = cnt;
    last_n  = last;
    unique case (state)
      ARB_IDLE, ARB_TURN: begin
        if (found) begin
          state_n = ARB_OWNED;
          grant_n = ONE << pick;
          owner_n = pick;
          busy_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          state_n = ARB_IDLE;
        end
      end
      ARB_OWNED: begin
        if (!own_req || (beat && limit && others)) begin
          state_n = ARB_TURN;
          grant_n = '0;
          busy_n  = 1'b0;
          last_n  = owner;
        end else if (beat && cnt != BEAT_SAT) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = ARB_IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_comb begin
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        s_we    = s_we | bus.m_we[i];
        s_addr  = s_addr | bus.m_addr[i*ADDR_W +: ADDR_W];
        s_wdata = s_wdata | bus.m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.s_req   = busy & own_req;
  assign bus.s_we    = s_we;
  assign bus.s_addr  = s_addr;
  assign bus.s_wdata = s_wdata;
  assign bus.m_grant = grant;
  assign bus.m_ready = bus.s_ready ? grant : '0;
  assign bus.m_rdata = bus.s_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed scenarios plus
// random traffic checked against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MB = 4;

  typedef struct {
    int           kind;
    int           idx;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            cyc;
  } ev_t;

  localparam int EV_GRANT = 0;
  localparam int EV_REL   = 1;
  localparam int EV_BEAT  = 2;

  logic clk = 1'b0;
  logic resetn;
  logic [2:0] owner;
  logic busy;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_bus_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .owner  (owner),
    .busy   (busy)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   scb_on = 1'b0;
  ev_t  q[$];
  int   glog[$];

  int   m_own = -1;
  int   m_last = N - 1;
  int   m_beats = 0;
  logic [N-1:0] prev_grant = '0;

  int   rem [N];
  int   bcnt [N];
  bit   rnd_start = 1'b0;
  bit   rnd_data = 1'b1;
  bit   rnd_ready = 1'b0;
  logic ready_val = 1'b0;
  logic [N-1:0] beat_seen;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rr_ref(logic [N-1:0] r, int from);
    for (int k = 1; k <= N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // reference model: whole-transaction view of ownership
  always @(negedge clk) begin
    ev_t e;
    logic [N-1:0] oth;
    int w;
    if (!resetn) begin
      m_own = -1;
      m_last = N - 1;
      m_beats = 0;
      q.delete();
    end else if (scb_on) begin
      if (m_own >= 0) begin
        oth = bus.m_req;
        oth[m_own] = 1'b0;
        if (bus.m_req[m_own] && bus.s_ready) begin
          e.kind = EV_BEAT; e.idx = m_own; e.cyc = cyc;
          e.addr = bus.m_addr[m_own*AW +: AW];
          e.we = bus.m_we[m_own];
          e.wdata = bus.m_wdata[m_own*DW +: DW];
          e.rdata = bus.s_rdata;
          q.push_back(e);
          m_beats++;
        end
        if (!bus.m_req[m_own] ||
            (bus.s_ready && m_beats >= MB && oth != '0)) begin
          e.kind = EV_REL; e.idx = m_own; e.cyc = cyc;
          q.push_back(e);
          m_last = m_own;
          m_own = -1;
        end
      end else begin
        w = rr_ref(bus.m_req, m_last);
        if (w >= 0) begin
          e.kind = EV_GRANT; e.idx = w; e.cyc = cyc;
          q.push_back(e);
          m_own = w;
          m_beats = 0;
        end
      end
    end
  end

  task automatic take(input int kind, output ev_t e, output bit ok);
    ok = 1'b0;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e = q.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("FAIL event_kind: got %0d expected %0d", kind, e.kind);
      end else ok = 1'b1;
    end
  endtask

  task automatic mon_step();
    ev_t e;
    bit ok;
    int gi;
    gi = -1;
    if ($countones(bus.m_grant) == 1)
      for (int i = 0; i < N; i++) if (bus.m_grant[i]) gi = i;
    if (bus.m_grant != prev_grant) begin
      if (bus.m_grant == '0) begin
        take(EV_REL, e, ok);
      end else begin
        if (prev_grant != '0) chk("grant_no_gap", prev_grant, 0);
        take(EV_GRANT, e, ok);
        if (ok) begin
          chk("grant_idx", gi, e.idx);
          chk("grant_owner", owner, e.idx);
          chk("grant_busy", busy, 1);
        end
        glog.push_back(gi);
      end
    end
    if (bus.m_grant == '0) chk("idle_sreq", {bus.s_req, bus.s_addr}, 0);
    if (bus.s_req && bus.s_ready) begin
      take(EV_BEAT, e, ok);
      if (ok) begin
        chk("beat_ready", bus.m_ready, N'(1) << e.idx);
        chk("beat_addr", bus.s_addr, e.addr);
        chk("beat_we", bus.s_we, e.we);
        chk("beat_wdata", bus.s_wdata, e.wdata);
        chk("beat_rdata", bus.m_rdata, e.rdata);
      end
    end
    if (q.size() > 0 && cyc - q[0].cyc > 1) begin
      e = q.pop_front();
      chk("missing_event", 0, 64'(e.kind) + 1);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (scb_on && resetn) mon_step();
    prev_grant = bus.m_grant;
  end

  // one clock of requester behaviour; returns at posedge+1
  task automatic tick();
    @(negedge clk);
    #2;
    beat_seen = (bus.s_req && bus.s_ready) ? bus.m_grant : '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (beat_seen[i]) begin
        bcnt[i]++;
        if (rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) bus.m_req[i] = 1'b0;
        end
      end else if (rnd_start && rem[i] == 0 && !bus.m_req[i] &&
                   $urandom_range(7) == 0) begin
        rem[i] = $urandom_range(8, 1);
        bus.m_req[i] = 1'b1;
      end
      if (rnd_data) begin
        bus.m_addr[i*AW +: AW] = AW'($urandom);
        bus.m_wdata[i*DW +: DW] = $urandom;
        bus.m_we[i] = 1'($urandom);
      end
    end
    bus.s_rdata = $urandom;
    bus.s_ready = rnd_ready ? ($urandom_range(3) != 0) : ready_val;
  endtask

  task automatic do_reset();
    scb_on = 1'b0;
    resetn = 1'b0;
    bus.m_req = '0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; bcnt[i] = 0; end
    tick();
    tick();
    #1;
    chk("rst_grant", bus.m_grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_sbus", {bus.s_req, bus.s_we, bus.s_addr, bus.s_wdata}, 0);
    resetn = 1'b1;
    scb_on = 1'b1;
  endtask

  initial begin
    int n;
    int base;
    int start;
    bit hold_ok;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    bus.m_req = '0; bus.m_we = '0; bus.m_addr = '0; bus.m_wdata = '0;
    bus.s_rdata = '0; bus.s_ready = 1'b0; resetn = 1'b0;

    do_reset();
    ready_val = 1'b0;
    bus.m_req[0] = 1'b1; rem[0] = 2;
    tick(); #1;
    chk("t1_grant", bus.m_grant, 4'b0001);
    chk("t1_busy", busy, 1);
    chk("t1_addr", bus.s_addr, bus.m_addr[AW-1:0]);
    ready_val = 1'b1;
    repeat (8) tick();
    chk("t1_idle", busy, 0);

    do_reset();
    base = glog.size();
    for (int i = 0; i < N; i++) rem[i] = 1;
    bus.m_req = '1;
    n = 0;
    while (glog.size() < base + 4 && n < 60) begin tick(); n++; end
    rem[0] = 1; bus.m_req[0] = 1'b1;
    n = 0;
    while (glog.size() < base + 5 && n < 60) begin tick(); n++; end
    chk("t2_grants", glog.size() - base, 5);
    for (int k = 0; k < 5; k++)
      if (base + k < glog.size())
        chk($sformatf("t2_order%0d", k), glog[base+k], exp_order[k]);
    repeat (4) tick();

    do_reset();
    rem[1] = 1000; bus.m_req[1] = 1'b1;
    n = 0;
    while (bcnt[1] < 2 && n < 20) begin tick(); n++; end
    bus.m_req[2] = 1'b1; rem[2] = 1;
    n = 0;
    while (bus.m_grant != '0 && n < 20) begin tick(); n++; end
    chk("t3_beats", bcnt[1], MB);
    tick(); #1;
    chk("t3_next", bus.m_grant, 4'b0100);

    n = 0;
    while (bus.m_grant != 4'b0010 && n < 20) begin tick(); n++; end
    hold_ok = 1'b1;
    start = bcnt[1];
    repeat (24) begin
      tick();
      if (bus.m_grant != 4'b0010 || !busy) hold_ok = 1'b0;
    end
    chk("t4_hold", hold_ok, 1);
    chk("t4_over20", (bcnt[1] - start) > 20, 1);
    bus.m_req[3] = 1'b1; rem[3] = 1;
    tick(); #1;
    chk("t4_release", bus.m_grant, 0);
    rem[1] = 0; bus.m_req[1] = 1'b0;
    repeat (8) tick();

    rnd_data = 1'b0;
    bus.m_we = 4'b1001;
    bus.m_wdata[0 +: DW] = 32'hDEADBEEF;
    bus.m_wdata[3*DW +: DW] = 32'h12345678;
    bus.m_req[0] = 1'b1; rem[0] = 1;
    tick(); #1;
    chk("t5_grant", bus.m_grant, 4'b0001);
    chk("t5_we", bus.s_we, 1);
    chk("t5_wdata", bus.s_wdata, 32'hDEADBEEF);
    chk("t5_ready", bus.m_ready, 4'b0001);
    repeat (4) tick();
    rnd_data = 1'b1;

    do_reset();
    bus.m_req[2] = 1'b1; rem[2] = 1000;
    tick(); tick(); #1;
    chk("t6_owner", owner, 2);
    chk("t6_busy", busy, 1);
    scb_on = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("t6_async_grant", bus.m_grant, 0);
    chk("t6_async_sreq", bus.s_req, 0);
    bus.m_req = 4'b0110;
    rem[1] = 1; rem[2] = 1;
    tick(); tick();
    resetn = 1'b1;
    scb_on = 1'b1;
    tick(); #1;
    chk("t6_first", bus.m_grant, 4'b0010);
    repeat (10) tick();

    rnd_start = 1'b1;
    rnd_ready = 1'b1;
    repeat (2000) tick();
    rnd_start = 1'b0;
    repeat (300) tick();
    chk("drain_queue", q.size(), 0);
    chk("drain_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
